branch_control: RTL

BRANCH_CONTROL -- requirements
Module: branch_control

---
 rtl/branch_pkg.sv | 25 ++
 rtl/branch_cond_eval.sv | 34 +++
 rtl/branch_control.sv | 131 +++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution controller: condition codes,
// status-register values and FSM states.
package branch_pkg;

   localparam logic [2:0] CC_NEVER  = 3'b000;
   localparam logic [2:0] CC_ALWAYS = 3'b001;
   localparam logic [2:0] CC_EQ     = 3'b010;
   localparam logic [2:0] CC_NE     = 3'b011;
   localparam logic [2:0] CC_LT     = 3'b100;
   localparam logic [2:0] CC_GE     = 3'b101;
   localparam logic [2:0] CC_GT     = 3'b110;
   localparam logic [2:0] CC_LE     = 3'b111;

   localparam logic [1:0] SR_CLR  = 2'b00;
   localparam logic [1:0] SR_NEG  = 2'b01;
   localparam logic [1:0] SR_ZERO = 2'b10;
   localparam logic [1:0] SR_POS  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_HAZARD = 2'b01,
      ST_FLUSH  = 2'b10
   } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition-code evaluation against the status register.
module branch_cond_eval
   import branch_pkg::*;
(
   input  logic [2:0] brCond,
   input  logic [1:0] srIn,
   output logic       taken
);

   logic w_neg;
   logic w_zero;
   logic w_pos;

   // a cleared status register matches none of the flags, so every conditional code falls through as not-taken
   assign w_neg  = (srIn == SR_NEG);
   assign w_zero = (srIn == SR_ZERO);
   assign w_pos  = (srIn == SR_POS);

   always_comb begin
      taken = 1'b0;
      case (brCond)
         CC_NEVER:  taken = 1'b0;
         CC_ALWAYS: taken = 1'b1;
         CC_EQ:     taken = w_zero;
         CC_NE:     taken = w_neg | w_pos;
         CC_LT:     taken = w_neg;
         CC_GE:     taken = w_zero | w_pos;
         CC_GT:     taken = w_pos;
         CC_LE:     taken = w_neg | w_zero;
         default:   taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_control.sv
// Branch resolution controller: waits out status-register hazards, acknowledges
// each request once, and squashes the pipeline for a fixed number of cycles after a taken branch.
//
// state     | meaning
// ST_IDLE   | waiting for a branch request
// ST_HAZARD | request held off while the status register is being written or stalled
// ST_FLUSH  | taken branch resolved, flush asserted until the counter expires
module branch_control
   import branch_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
)(
   input  logic             CLK,
   input  logic             reset,
   input  logic             brValid,
   input  logic [2:0]       brCond,
   input  logic [1:0]       srIn,
   input  logic             SRw,
   input  logic             stall,
   output logic             brDone,
   output logic             takeBranch,
   output logic             pcSel,
   output logic             flush,
   output logic             busy,
   output logic [CNT_W-1:0] brCount
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_flush_cnt;
   logic [2:0]       w_flush_cnt_nxt;
   logic             r_done;
   logic             r_take;
   logic             r_flush;
   logic             r_busy;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic             w_done_nxt;
   logic             w_take_nxt;
   logic             w_flush_nxt;
   logic             w_eval;
   logic             w_taken;

   branch_cond_eval u_cond_eval (
      .brCond (brCond),
      .srIn   (srIn),
      .taken  (w_taken)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      w_count_nxt     = r_count;
      w_done_nxt      = 1'b0;
      w_take_nxt      = 1'b0;
      w_flush_nxt     = r_flush;
      w_eval          = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // r_done blocks the edge that closes an acknowledge cycle
            if (brValid && !stall && !r_done) begin
               if (SRw) w_state_nxt = ST_HAZARD;
               else     w_eval      = 1'b1;
            end
         end
         ST_HAZARD: begin
            if (!SRw && !stall) w_eval = 1'b1;
         end
         ST_FLUSH: begin
            if (!stall) begin
               if (r_flush_cnt == 3'd0) begin
                  w_state_nxt = ST_IDLE;
                  w_flush_nxt = 1'b0;
               end else begin
                  w_flush_cnt_nxt = r_flush_cnt - 3'd1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_flush_nxt = 1'b0;
         end
      endcase

      if (w_eval) begin
         w_done_nxt = 1'b1;
         w_take_nxt = w_taken;
         if (w_taken) begin
            w_state_nxt     = ST_FLUSH;
            w_flush_nxt     = 1'b1;
            w_flush_cnt_nxt = FLUSH_LOAD;
            if (r_count != {CNT_W{1'b1}}) w_count_nxt = r_count + CNT_W'(1);
         end else begin
            w_state_nxt = ST_IDLE;
            w_flush_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_flush_cnt <= 3'd0;
         r_count     <= '0;
         r_done      <= 1'b0;
         r_take      <= 1'b0;
         r_flush     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
         r_count     <= w_count_nxt;
         r_done      <= w_done_nxt;
         r_take      <= w_take_nxt;
         r_flush     <= w_flush_nxt;
         r_busy      <= (w_state_nxt != ST_IDLE);
      end
   end

   assign brDone     = r_done;
   assign takeBranch = r_take;
   assign pcSel      = r_take;
   assign flush      = r_flush;
   assign busy       = r_busy;
   assign brCount    = r_count;

endmodule
